// File: rtl/reg_bank_sweep_pkg.sv
// rtl/reg_bank_sweep_pkg.sv - shared state encoding and sizing helper for reg_bank_sweep
package reg_bank_sweep_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   // Smallest n with 2**n >= value; a value of 1 still gets one address bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/reg_bank_sweep_ctl.sv
// rtl/reg_bank_sweep_ctl.sv - sweep sequencer: FSM, clear counter, Busy and WrDrop
module reg_bank_sweep_ctl
   import reg_bank_sweep_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = clog2(DEPTH)
)(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Tick,
   input  logic              WrEn,
   input  logic              ClearReq,
   output logic              Busy,
   output logic              WrDrop,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         WrDrop <= 1'b0;
      end else if (Tick) begin
         WrDrop <= WrEn && (state == ST_SWEEP);
         case (state)
            ST_IDLE: begin
               if (ClearReq) begin
                  state <= ST_SWEEP;
                  cnt   <= '0;
               end
            end
            default: begin
               // ClearReq is ignored here; the sweep always runs to the last word.
               if (cnt == LAST_ADDR) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
         endcase
      end
   end

   assign Busy       = (state == ST_SWEEP);
   assign sweep_we   = Tick && (state == ST_SWEEP);
   assign sweep_addr = cnt;

endmodule

// File: rtl/reg_bank_sweep.sv
// rtl/reg_bank_sweep.sv - DEPTHxWIDTH Tick-gated register bank, 2 read / 1 write, background clear
module reg_bank_sweep
   import reg_bank_sweep_pkg::*;
#(
   parameter int              WIDTH     = 32,
   parameter int              DEPTH     = 32,
   parameter int              ADDR_W    = clog2(DEPTH),
   parameter int              ZERO_REG  = 1,
   parameter int              BYPASS    = 1,
   parameter logic [WIDTH-1:0] CLEAR_VAL = '0
)(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Tick,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [WIDTH-1:0]  WrData,
   input  logic [ADDR_W-1:0] RdAddrA,
   output logic [WIDTH-1:0]  RdDataA,
   input  logic [ADDR_W-1:0] RdAddrB,
   output logic [WIDTH-1:0]  RdDataB,
   input  logic              ClearReq,
   output logic              Busy,
   output logic              WrDrop
);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              zero_hit;
   logic              wr_fire;
   logic              byp_ok;

   reg_bank_sweep_ctl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ctl (
      .Clock      (Clock),
      .Reset      (Reset),
      .Tick       (Tick),
      .WrEn       (WrEn),
      .ClearReq   (ClearReq),
      .Busy       (Busy),
      .WrDrop     (WrDrop),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   assign zero_hit = (ZERO_REG != 0) && (WrAddr == '0);
   assign wr_fire  = Tick && WrEn && !Busy && !zero_hit;
   assign byp_ok   = (BYPASS != 0) && Tick && WrEn && !Busy;

   // Sweep and port writes never coincide: the port is locked out while Busy.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (sweep_we) begin
         mem[sweep_addr] <= CLEAR_VAL;
      end else if (wr_fire) begin
         mem[WrAddr] <= WrData;
      end
   end

   always_comb begin
      RdDataA = mem[RdAddrA];
      if (byp_ok && (RdAddrA == WrAddr)) begin
         RdDataA = WrData;
      end
      if ((ZERO_REG != 0) && (RdAddrA == '0)) begin
         RdDataA = '0;
      end
   end

   always_comb begin
      RdDataB = mem[RdAddrB];
      if (byp_ok && (RdAddrB == WrAddr)) begin
         RdDataB = WrData;
      end
      if ((ZERO_REG != 0) && (RdAddrB == '0)) begin
         RdDataB = '0;
      end
   end

endmodule
